// File: rtl/region_select_pkg.sv
// region_select_pkg: FSM states and tile geometry helpers shared by region_select_writer.
package region_select_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  function automatic int unsigned h_off_f(input int unsigned idx, input int unsigned cols,
                                          input int unsigned tw);
    return (idx % cols) * tw;
  endfunction

  function automatic int unsigned v_off_f(input int unsigned idx, input int unsigned cols,
                                          input int unsigned th);
    return (idx / cols) * th;
  endfunction

  function automatic int unsigned tile_addr_f(input int unsigned idx, input int unsigned cols,
                                              input int unsigned tw, input int unsigned th,
                                              input int unsigned iw);
    return h_off_f(idx, cols, tw) + iw * v_off_f(idx, cols, th);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises an active-low button, debounces its level and
// pulses o_press for one cycle on each accepted press (1->0 transition).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_hit;

  assign w_diff = r_sync[1] != r_level;
  assign w_hit  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      o_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_cnt   <= (w_hit || !w_diff) ? '0 : r_cnt + 1'b1;
      r_level <= w_hit ? r_sync[1] : r_level;
      o_press <= w_hit && !r_sync[1];
    end
  end

endmodule

// File: rtl/region_select_writer.sv
// region_select_writer: button-driven tile selector that writes the selected
// tile's base address as a little-endian descriptor into byte-wide RAM port A.
module region_select_writer
  import region_select_pkg::*;
#(
  parameter int                GRID_COLS       = 4,
  parameter int                GRID_ROWS       = 4,
  parameter int                TILE_W          = 100,
  parameter int                TILE_H          = 100,
  parameter int                IMG_W           = 400,
  parameter int                ADDR_W          = 19,
  parameter int                OFF_W           = 9,
  parameter int                DATA_BYTES      = 4,
  parameter logic [ADDR_W-1:0] DESC_ADDR       = 19'h30E4D,
  parameter int                DEBOUNCE_CYCLES = 500000
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   up_btn_n,
  input  logic                                   down_btn_n,
  input  logic                                   commit,
  output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0] tile_index,
  output logic [OFF_W-1:0]                       h_offset,
  output logic [OFF_W-1:0]                       v_offset,
  output logic [ADDR_W-1:0]                      tile_addr,
  output logic [ADDR_W-1:0]                      ram_addr,
  output logic [7:0]                             ram_wdata,
  output logic                                   ram_wren,
  output logic                                   busy,
  output logic                                   done
);
  localparam int IDX_W = $clog2(GRID_COLS * GRID_ROWS);
  localparam int N     = GRID_COLS * GRID_ROWS;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int KW    = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;

  if (DW < ADDR_W) begin : g_width_check
    $error("region_select_writer: 8*DATA_BYTES must be >= ADDR_W");
  end

  logic              w_up, w_dn;
  logic [IDX_W-1:0]  r_idx;
  state_t            r_state, w_state;
  logic [KW-1:0]     r_k, w_k;
  logic [DW-1:0]     r_snap, w_snap;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [7:0]        r_wdata, w_wdata;
  logic              r_wren, w_wren, r_done, w_done;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(reset_n), .i_btn_n(up_btn_n), .o_press(w_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk(clk), .rst_n(reset_n), .i_btn_n(down_btn_n), .o_press(w_dn)
  );

  // Simultaneous up+down cancel; presses during a transfer are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_idx <= '0;
    else if (!busy && (w_up ^ w_dn))
      r_idx <= w_up ? ((r_idx == IDX_W'(N - 1)) ? '0 : r_idx + 1'b1)
                    : ((r_idx == '0) ? IDX_W'(N - 1) : r_idx - 1'b1);
  end

  assign tile_index = r_idx;
  assign h_offset   = OFF_W'(h_off_f(32'(r_idx), GRID_COLS, TILE_W));
  assign v_offset   = OFF_W'(v_off_f(32'(r_idx), GRID_COLS, TILE_H));
  assign tile_addr  = ADDR_W'(tile_addr_f(32'(r_idx), GRID_COLS, TILE_W, TILE_H, IMG_W));
  assign busy       = r_state != IDLE;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign ram_wren   = r_wren;
  assign done       = r_done;

  // Outputs are computed one state ahead so every RAM signal comes from a flop.
  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_snap  = r_snap;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_wren  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (commit) begin
        w_state = WRITE;
        w_k     = '0;
        w_snap  = DW'(tile_addr);
        w_wren  = 1'b1;
        w_addr  = DESC_ADDR;
        w_wdata = w_snap[7:0];
      end
      WRITE: if (r_k == KW'(DATA_BYTES - 1)) begin
        w_state = DONE;
        w_done  = 1'b1;
      end else begin
        w_k     = r_k + 1'b1;
        w_wren  = 1'b1;
        w_addr  = DESC_ADDR + ADDR_W'(w_k);
        w_wdata = 8'(r_snap >> (8 * w_k));
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_snap  <= '0;
      r_addr  <= DESC_ADDR;
      r_wdata <= '0;
      r_wren  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_k     <= w_k;
      r_snap  <= w_snap;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_wren  <= w_wren;
      r_done  <= w_done;
    end
  end

endmodule

// File: tb/tb_region_select_writer.sv
// tb_region_select_writer: directed tests of tile selection, descriptor writes,
// debouncing, busy gating and mid-write reset.
module tb_region_select_writer;
  localparam logic [18:0] DESC = 19'h30E4D;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        up_btn_n = 1'b1;
  logic        down_btn_n = 1'b1;
  logic        commit = 1'b0;
  logic [3:0]  tile_index;
  logic [8:0]  h_offset, v_offset;
  logic [18:0] tile_addr, ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wren, busy, done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [18:0] wq_a[$];
  logic [7:0]  wq_d[$];

  region_select_writer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .up_btn_n(up_btn_n), .down_btn_n(down_btn_n),
    .commit(commit), .tile_index(tile_index), .h_offset(h_offset), .v_offset(v_offset),
    .tile_addr(tile_addr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      wq_a.push_back(ram_addr);
      wq_d.push_back(ram_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic press(input bit up, input bit dn);
    @(negedge clk);
    up_btn_n = !up;
    down_btn_n = !dn;
    repeat (10) @(negedge clk);
    up_btn_n = 1'b1;
    down_btn_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", tile_index); end
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", ram_wren); end
    checks++; if (ram_addr !== DESC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", ram_addr, DESC); end
    checks++; if (ram_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", ram_wdata); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL post_reset_idx got=%0d exp=0", tile_index); end
  endtask

  task automatic test_up_commit;
    logic [7:0] exp_d[4] = '{8'hA4, 8'h9C, 8'h00, 8'h00};
    int cyc;
    int d0;
    repeat (5) press(1'b1, 1'b0);
    checks++; if (tile_index !== 4'd5) begin failures++; $display("FAIL up5_idx got=%0d exp=5", tile_index); end
    checks++; if (h_offset !== 9'd100) begin failures++; $display("FAIL up5_h got=%0d exp=100", h_offset); end
    checks++; if (v_offset !== 9'd100) begin failures++; $display("FAIL up5_v got=%0d exp=100", v_offset); end
    checks++; if (tile_addr !== 19'h09CA4) begin failures++; $display("FAIL up5_addr got=%h exp=09ca4", tile_addr); end
    wq_a.delete(); wq_d.delete(); d0 = done_cnt;
    @(negedge clk) commit = 1'b1;
    @(negedge clk) commit = 1'b0;
    cyc = 1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up5_busy got=%b exp=1", busy); end
    while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 5) begin failures++; $display("FAIL up5_done_latency got=%0d exp=5", cyc); end
    repeat (3) @(negedge clk);
    checks++; if (wq_d.size() != 4) begin failures++; $display("FAIL up5_nbytes got=%0d exp=4", wq_d.size()); end
    for (int i = 0; i < 4 && i < wq_d.size(); i++) begin
      checks++;
      if (wq_d[i] !== exp_d[i] || wq_a[i] !== DESC + 19'(i)) begin
        failures++; $display("FAIL up5_byte%0d got=%h@%h exp=%h@%h", i, wq_d[i], wq_a[i], exp_d[i], DESC + 19'(i));
      end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL up5_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_d[4] = '{8'hEC, 8'hD5, 8'h01, 8'h00};
    repeat (10) press(1'b1, 1'b0);
    checks++; if (tile_index !== 4'd15) begin failures++; $display("FAIL wrap_idx15 got=%0d exp=15", tile_index); end
    checks++; if (tile_addr !== 19'h1D5EC) begin failures++; $display("FAIL wrap_addr got=%h exp=1d5ec", tile_addr); end
    wq_a.delete(); wq_d.delete();
    @(negedge clk) commit = 1'b1;
    @(negedge clk) commit = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (wq_d.size() != 4) begin failures++; $display("FAIL wrap_nbytes got=%0d exp=4", wq_d.size()); end
    for (int i = 0; i < 4 && i < wq_d.size(); i++) begin
      checks++;
      if (wq_d[i] !== exp_d[i] || wq_a[i] !== DESC + 19'(i)) begin
        failures++; $display("FAIL wrap_byte%0d got=%h@%h exp=%h@%h", i, wq_d[i], wq_a[i], exp_d[i], DESC + 19'(i));
      end
    end
    press(1'b1, 1'b0);
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL wrap_up got=%0d exp=0", tile_index); end
    press(1'b0, 1'b1);
    checks++; if (tile_index !== 4'd15) begin failures++; $display("FAIL wrap_down got=%0d exp=15", tile_index); end
  endtask

  task automatic test_glitch;
    repeat (3) begin
      @(negedge clk) up_btn_n = 1'b0;
      repeat (2) @(negedge clk);
      up_btn_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checks++; if (tile_index !== 4'd15) begin failures++; $display("FAIL glitch_ignored got=%0d exp=15", tile_index); end
    press(1'b1, 1'b0);
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL glitch_hold got=%0d exp=0", tile_index); end
    press(1'b1, 1'b1);
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL both_pressed got=%0d exp=0", tile_index); end
  endtask

  task automatic test_back_to_back;
    int d0;
    wq_a.delete(); wq_d.delete(); d0 = done_cnt;
    @(negedge clk) up_btn_n = 1'b0;
    repeat (3) @(negedge clk);
    commit = 1'b1;
    repeat (3) @(negedge clk);
    commit = 1'b0;
    repeat (4) @(negedge clk);
    up_btn_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (wq_d.size() != 4) begin failures++; $display("FAIL b2b_nbytes got=%0d exp=4", wq_d.size()); end
    for (int i = 0; i < wq_d.size(); i++) begin
      checks++; if (wq_d[i] !== 8'h00) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=00", i, wq_d[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL b2b_idx got=%0d exp=0", tile_index); end
  endtask

  task automatic test_reset_mid;
    int d0;
    repeat (2) press(1'b1, 1'b0);
    checks++; if (tile_addr !== 19'd200) begin failures++; $display("FAIL mid_pre_addr got=%h exp=000c8", tile_addr); end
    wq_a.delete(); wq_d.delete(); d0 = done_cnt;
    @(negedge clk) commit = 1'b1;
    @(negedge clk) commit = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ram_addr !== DESC + 19'd2 || ram_wren !== 1'b1) begin failures++; $display("FAIL mid_k2 got=%h wren=%b exp=%h wren=1", ram_addr, ram_wren, DESC + 19'd2); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL mid_wren got=%b exp=0", ram_wren); end
    checks++; if (tile_index !== 4'd0) begin failures++; $display("FAIL mid_idx got=%0d exp=0", tile_index); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (wq_d.size() != 3) begin failures++; $display("FAIL mid_nbytes got=%0d exp=3", wq_d.size()); end
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL mid_done got=%0d exp=0", done_cnt - d0); end
    wq_a.delete(); wq_d.delete();
    @(negedge clk) commit = 1'b1;
    @(negedge clk) commit = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (wq_d.size() != 4) begin failures++; $display("FAIL mid_after_nbytes got=%0d exp=4", wq_d.size()); end
    for (int i = 0; i < wq_d.size(); i++) begin
      checks++; if (wq_d[i] !== 8'h00) begin failures++; $display("FAIL mid_after_byte%0d got=%h exp=00", i, wq_d[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL mid_after_done got=%0d exp=1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_up_commit();
    test_wrap();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
